rc_servo_frame_scheduler: RTL and testbench

//  Time-shares one pulse-width counter between the X and Y servo channels within a fixed 20 ms frame.

---
 rtl/rc_servo_pkg.sv | 34 +++
 rtl/servo_tick_gen.sv | 30 +++
 rtl/rc_servo_frame_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_rc_servo_frame_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rc_servo_pkg.sv
// Shared types and default timing for the RC servo frame scheduler.
package rc_servo_pkg;

  // Default timing: 1 us tick at 10 MHz, 20 ms frame, 1.0 ms .. 2.02 ms pulses.
  localparam int unsigned CLK_DIV_DEF     = 10;
  localparam int unsigned FRAME_TICKS_DEF = 20000;
  localparam int unsigned MIN_TICKS_DEF   = 1000;
  localparam int unsigned STEP_TICKS_DEF  = 4;
  localparam int unsigned POS_W_DEF       = 8;
  localparam int unsigned SLEW_STEP_DEF   = 4;

  // Axis lanes share one width counter; lane order is also pulse order.
  localparam int unsigned NUM_AXES = 2;
  localparam int unsigned AXIS_X   = 0;
  localparam int unsigned AXIS_Y   = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_PULSE_X = 3'd2,
    ST_PULSE_Y = 3'd3,
    ST_GAP     = 3'd4
  } frame_state_e;

  // Pulse width in ticks for a position command.
  function automatic int unsigned width_ticks(
    input int unsigned pos,
    input int unsigned min_ticks  = MIN_TICKS_DEF,
    input int unsigned step_ticks = STEP_TICKS_DEF
  );
    return min_ticks + pos * step_ticks;
  endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// CLK_DIV prescaler: one-cycle tick every CLK_DIV clocks, restartable via clear_i.
module servo_tick_gen #(
  parameter int unsigned CLK_DIV = 10
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned      CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CNT_LAST);

  // Wrap on the tick; a clear restarts the period so the next tick is a full CLK_DIV away.
  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
    if (clear_i) cnt_d = '0;
  end

  // Prescaler count register.
  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rc_servo_frame_scheduler.sv
// X/Y servo frame scheduler: one shared width counter, X pulse then Y pulse then gap,
// fixed LOAD-to-LOAD period. Commands land in per-axis shadow regs and are applied at LOAD.
// Optional build macro SERVO_SLEW_LIMIT_EN: active position steps toward shadow by at
// most SLEW_STEP per frame instead of jumping.
module rc_servo_frame_scheduler
  import rc_servo_pkg::*;
#(
  parameter int unsigned CLK_DIV     = CLK_DIV_DEF,
  parameter int unsigned FRAME_TICKS = FRAME_TICKS_DEF,
  parameter int unsigned MIN_TICKS   = MIN_TICKS_DEF,
  parameter int unsigned STEP_TICKS  = STEP_TICKS_DEF,
  parameter int unsigned POS_W       = POS_W_DEF,
  parameter int unsigned SLEW_STEP   = SLEW_STEP_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic [POS_W-1:0] pos_x_i,
  input  logic             pos_x_valid_i,
  output logic             pos_x_ready_o,
  input  logic [POS_W-1:0] pos_y_i,
  input  logic             pos_y_valid_i,
  output logic             pos_y_ready_o,
  output logic             pwm_x_o,
  output logic             pwm_y_o,
  output logic             frame_start_o
);

  localparam int unsigned      W_MAX      = width_ticks((1 << POS_W) - 1, MIN_TICKS, STEP_TICKS);
  localparam int unsigned      WID_W      = $clog2(W_MAX + 1);
  localparam int unsigned      FRAME_CLKS = FRAME_TICKS * CLK_DIV;
  localparam int unsigned      FCNT_W     = $clog2(FRAME_CLKS);
  localparam logic [POS_W-1:0] POS_CENTRE = {1'b1, {(POS_W-1){1'b0}}};

  // Both pulses must fit inside one frame with room for the gap decision.
  if (2 * W_MAX >= FRAME_TICKS) begin : g_frame_too_short
    $error("rc_servo_frame_scheduler: 2*W(max)=%0d must be < FRAME_TICKS=%0d", 2 * W_MAX, FRAME_TICKS);
  end
  if (CLK_DIV < 2 || SLEW_STEP == 0) begin : g_bad_cfg
    $error("rc_servo_frame_scheduler: CLK_DIV must be >= 2 and SLEW_STEP > 0");
  end

  frame_state_e state_q, state_d;
  logic [WID_W-1:0]  wcnt_q, wcnt_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              pwm_x_q, pwm_x_d, pwm_y_q, pwm_y_d;
  logic              tick, tick_clr, in_load;
  logic [WID_W-1:0]  width_x_load, width_y_load;

  logic [NUM_AXES-1:0][POS_W-1:0] cmd_pos, active_pos, active_nxt;
  logic [NUM_AXES-1:0]            cmd_valid;

  assign in_load   = (state_q == ST_LOAD);
  assign cmd_pos   = {pos_y_i, pos_x_i};
  assign cmd_valid = {pos_y_valid_i, pos_x_valid_i};

  // Prescaler restarts in LOAD so every pulse begins on a fresh tick period.
  assign tick_clr = ~enable_i | (state_q == ST_IDLE) | in_load;

  servo_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (tick_clr),
    .tick_o  (tick)
  );

  for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
    logic [POS_W-1:0] shadow_q, shadow_d, active_q, active_d;
    logic             accept;

    assign accept        = cmd_valid[a] & ~in_load;
    assign active_pos[a] = active_q;
    assign active_nxt[a] = active_d;

    // Shadow holds the newest accepted command; active only moves in LOAD.
    always_comb begin
      shadow_d = accept ? cmd_pos[a] : shadow_q;
      active_d = active_q;
`ifdef SERVO_SLEW_LIMIT_EN
      if (in_load) begin
        if (shadow_q > active_q)
          active_d = (shadow_q - active_q > POS_W'(SLEW_STEP)) ? active_q + POS_W'(SLEW_STEP) : shadow_q;
        else if (shadow_q < active_q)
          active_d = (active_q - shadow_q > POS_W'(SLEW_STEP)) ? active_q - POS_W'(SLEW_STEP) : shadow_q;
      end
`else
      if (in_load) active_d = shadow_q;
`endif
    end

    // Per-axis position registers; reset parks the servo at centre.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        shadow_q <= POS_CENTRE;
        active_q <= POS_CENTRE;
      end else begin
        shadow_q <= shadow_d;
        active_q <= active_d;
      end
    end
  end

  // X width uses the value being latched this LOAD; Y width is read when X ends.
  assign width_x_load = WID_W'(width_ticks(32'(active_nxt[AXIS_X]), MIN_TICKS, STEP_TICKS));
  assign width_y_load = WID_W'(width_ticks(32'(active_pos[AXIS_Y]), MIN_TICKS, STEP_TICKS));

  // Frame sequencing: counts ticks for pulse widths and clocks for the frame period.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    fcnt_d  = fcnt_q + FCNT_W'(1);
    if (!enable_i) begin
      state_d = ST_IDLE;
      wcnt_d  = '0;
      fcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_LOAD;
          fcnt_d  = '0;
        end
        ST_LOAD: begin
          state_d = ST_PULSE_X;
          wcnt_d  = width_x_load;
          fcnt_d  = '0;
        end
        ST_PULSE_X: begin
          if (tick) begin
            if (wcnt_q == WID_W'(1)) begin
              state_d = ST_PULSE_Y;
              wcnt_d  = width_y_load;
            end else begin
              wcnt_d = wcnt_q - WID_W'(1);
            end
          end
        end
        ST_PULSE_Y: begin
          if (tick) begin
            if (wcnt_q == WID_W'(1)) begin
              state_d = ST_GAP;
              wcnt_d  = '0;
            end else begin
              wcnt_d = wcnt_q - WID_W'(1);
            end
          end
        end
        ST_GAP: begin
          // fcnt is 0 in the cycle after LOAD, so this lands the next LOAD FRAME_CLKS after the last.
          if (fcnt_q == FCNT_W'(FRAME_CLKS - 2)) state_d = ST_LOAD;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    pwm_x_d = (state_d == ST_PULSE_X);
    pwm_y_d = (state_d == ST_PULSE_Y);
  end

  // FSM, counters and registered pwm pins.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      fcnt_q  <= '0;
      pwm_x_q <= 1'b0;
      pwm_y_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      fcnt_q  <= fcnt_d;
      pwm_x_q <= pwm_x_d;
      pwm_y_q <= pwm_y_d;
    end
  end

  assign pwm_x_o       = pwm_x_q;
  assign pwm_y_o       = pwm_y_q;
  assign frame_start_o = in_load;
  assign pos_x_ready_o = ~in_load;
  assign pos_y_ready_o = ~in_load;

endmodule

// File: tb/tb_rc_servo_frame_scheduler.sv
// Bench for rc_servo_frame_scheduler: directed sequence with random commands, checked
// against a frame-level model (shadow/active positions, width = MIN + pos*STEP ticks).
module tb_rc_servo_frame_scheduler;

  localparam int CLK_DIV     = 3;
  localparam int FRAME_TICKS = 1300;
  localparam int MIN_TICKS   = 100;
  localparam int STEP_TICKS  = 2;
  localparam int POS_W       = 8;
  localparam int SLEW_STEP   = 4;
  localparam int FRAME_CLKS  = FRAME_TICKS * CLK_DIV;
  localparam int CENTRE      = 1 << (POS_W - 1);
  localparam int POS_MAX     = (1 << POS_W) - 1;

  logic             clk = 1'b0;
  logic             reset_i, enable_i;
  logic [POS_W-1:0] pos_x_i, pos_y_i;
  logic             pos_x_valid_i, pos_y_valid_i;
  logic             pos_x_ready_o, pos_y_ready_o;
  logic             pwm_x_o, pwm_y_o, frame_start_o;

  int n_assert = 0;
  int n_fail   = 0;
  int m_sh[2];
  int m_ac[2];
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  rc_servo_frame_scheduler #(
    .CLK_DIV     (CLK_DIV),
    .FRAME_TICKS (FRAME_TICKS),
    .MIN_TICKS   (MIN_TICKS),
    .STEP_TICKS  (STEP_TICKS),
    .POS_W       (POS_W),
    .SLEW_STEP   (SLEW_STEP)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .enable_i      (enable_i),
    .pos_x_i       (pos_x_i),
    .pos_x_valid_i (pos_x_valid_i),
    .pos_x_ready_o (pos_x_ready_o),
    .pos_y_i       (pos_y_i),
    .pos_y_valid_i (pos_y_valid_i),
    .pos_y_ready_o (pos_y_ready_o),
    .pwm_x_o       (pwm_x_o),
    .pwm_y_o       (pwm_y_o),
    .frame_start_o (frame_start_o)
  );

  function automatic int wt(input int p);
    return MIN_TICKS + p * STEP_TICKS;
  endfunction

  // Ready is low only in LOAD, i.e. frame-relative cycle 0 (or FRAME_CLKS, the next LOAD).
  function automatic int exp_rdy(input int c);
    return (c % FRAME_CLKS == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Frame start: active follows shadow (optionally rate-limited).
  task automatic model_load();
    for (int a = 0; a < 2; a++) begin
`ifdef SERVO_SLEW_LIMIT_EN
      if (m_sh[a] > m_ac[a] + SLEW_STEP)      m_ac[a] = m_ac[a] + SLEW_STEP;
      else if (m_sh[a] < m_ac[a] - SLEW_STEP) m_ac[a] = m_ac[a] - SLEW_STEP;
      else                                    m_ac[a] = m_sh[a];
`else
      m_ac[a] = m_sh[a];
`endif
    end
  endtask

  // Starts at the negedge of a LOAD cycle (c=0); runs to the next LOAD and checks the frame.
  // Optionally presents a command for inj_len cycles starting at frame cycle inj_c.
  task automatic frame(input string tag, input int inj_c, input int inj_len,
                       input bit [1:0] mask, input int vx, input int vy);
    int per, xw, yw, xr, yr, rdy0, rdy1, ex, ey;
    per = -1; xw = 0; yw = 0; xr = -1; yr = -1; rdy0 = -1; rdy1 = -1;
    ex = wt(m_ac[0]) * CLK_DIV;
    ey = wt(m_ac[1]) * CLK_DIV;
    for (int c = 0; c <= FRAME_CLKS + 20; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (pwm_x_o) begin xw++; if (xr < 0) xr = c; end
        if (pwm_y_o) begin yw++; if (yr < 0) yr = c; end
        if (c == inj_c + 1) rdy1 = int'({pos_y_ready_o, pos_x_ready_o});
        if (frame_start_o) begin per = c; break; end
      end
      if (c == inj_c) begin
        rdy0 = int'({pos_y_ready_o, pos_x_ready_o});
        if (mask[0]) begin pos_x_i = POS_W'(vx); pos_x_valid_i = 1'b1; end
        if (mask[1]) begin pos_y_i = POS_W'(vy); pos_y_valid_i = 1'b1; end
      end
      if (c == inj_c + inj_len) begin
        pos_x_valid_i = 1'b0;
        pos_y_valid_i = 1'b0;
      end
    end
    pos_x_valid_i = 1'b0;
    pos_y_valid_i = 1'b0;
    chk({tag, ".period"},  per, FRAME_CLKS);
    chk({tag, ".x_rise"},  xr, 1);
    chk({tag, ".x_width"}, xw, ex);
    chk({tag, ".y_rise"},  yr, 1 + ex);
    chk({tag, ".y_width"}, yw, ey);
    if (inj_c >= 0) begin
      chk({tag, ".rdy_cmd"},  rdy0, exp_rdy(inj_c));
      chk({tag, ".rdy_next"}, rdy1, exp_rdy(inj_c + 1));
      if (mask[0]) m_sh[0] = vx;
      if (mask[1]) m_sh[1] = vy;
    end
    model_load();
  endtask

  // Pulses must never overlap.
  always @(negedge clk) begin
    if (mon_en) begin
      n_assert++;
      assert (!(pwm_x_o && pwm_y_o)) else begin
        n_fail++;
        $error("FAIL overlap: observed x=%0b y=%0b expected not both high", pwm_x_o, pwm_y_o);
      end
    end
  end

  initial begin
    #(3ms);
    $display("FAIL watchdog: observed simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, hi, fsn, found, v;
    reset_i = 1'b1; enable_i = 1'b0;
    pos_x_i = '0; pos_y_i = '0; pos_x_valid_i = 1'b0; pos_y_valid_i = 1'b0;
    m_sh[0] = CENTRE; m_sh[1] = CENTRE; m_ac[0] = CENTRE; m_ac[1] = CENTRE;

    repeat (3) @(negedge clk);
    chk("rst.pwm_x", pwm_x_o, 0);
    chk("rst.pwm_y", pwm_y_o, 0);
    chk("rst.frame_start", frame_start_o, 0);
    chk("rst.ready", {pos_y_ready_o, pos_x_ready_o}, 3);
    reset_i = 1'b0;

    repeat (4) @(negedge clk);
    chk("idle.pwm_x", pwm_x_o, 0);
    chk("idle.frame_start", frame_start_o, 0);

    mon_en = 1'b1;
    enable_i = 1'b1;
    @(negedge clk);
    chk("en.frame_start", frame_start_o, 1);
    model_load();

    frame("f1_centre", -1, 0, 2'b00, 0, 0);
    frame("f2_cmd_mid", 700, 1, 2'b11, 0, POS_MAX);
    v = $urandom_range(1, POS_MAX - 1);
    frame("f3_hold_load", 0, 2, 2'b01, v, 0);
    frame("f4_after_hold", -1, 0, 2'b00, 0, 0);
    frame("f5_last_cycle", FRAME_CLKS - 1, 1, 2'b10, 0, $urandom_range(0, POS_MAX));
    for (int i = 0; i < 3; i++)
      frame("rnd", $urandom_range(1, FRAME_CLKS - 10), $urandom_range(1, 3),
            2'($urandom_range(1, 3)), $urandom_range(0, POS_MAX), $urandom_range(0, POS_MAX));

    // Drop enable in the middle of the X pulse.
    k = $urandom_range(2, wt(m_ac[0]) * CLK_DIV - 2);
    repeat (k) @(negedge clk);
    chk("dis.x_before", pwm_x_o, 1);
    enable_i = 1'b0;
    @(negedge clk);
    chk("dis.x_low", pwm_x_o, 0);
    chk("dis.ready", {pos_y_ready_o, pos_x_ready_o}, 3);
    hi = 0; fsn = 0;
    repeat (2 * wt(POS_MAX) * CLK_DIV) begin
      @(negedge clk);
      hi  += int'(pwm_x_o | pwm_y_o);
      fsn += int'(frame_start_o);
    end
    chk("dis.no_pulse", hi, 0);
    chk("dis.no_frame", fsn, 0);
    enable_i = 1'b1;
    @(negedge clk);
    chk("reen.frame_start", frame_start_o, 1);
    model_load();
    frame("f_reen", 1500, 1, 2'b11, $urandom_range(0, POS_MAX), $urandom_range(0, POS_MAX));

    // Reset in the middle of the X pulse returns both axes to centre.
    repeat (5) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    chk("rst2.pwm_x", pwm_x_o, 0);
    chk("rst2.pwm_y", pwm_y_o, 0);
    chk("rst2.frame_start", frame_start_o, 0);
    @(negedge clk);
    reset_i = 1'b0;
    m_sh[0] = CENTRE; m_sh[1] = CENTRE; m_ac[0] = CENTRE; m_ac[1] = CENTRE;
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      @(negedge clk);
      found = int'(frame_start_o);
    end
    chk("rst2.frame_found", found, 1);
    model_load();
    frame("f_post_rst", -1, 0, 2'b00, 0, 0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
